// File: rtl/vliw_pkg.sv
// vliw_pkg: shared widths, NOP encoding and fetch FSM states for the VLIW front end
package vliw_pkg;
  localparam int INST_W = 32;
  localparam logic [INST_W-1:0] NOP_INST = 32'h0000_0000;
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DROP} fetch_state_t;
endpackage

// File: rtl/fetch_buffer.sv
// fetch_buffer: DEPTH-entry FIFO of {bundle, pc}; flush wins over push, push allowed when full if popping
module fetch_buffer #(
  parameter int W = 160,
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [W-1:0]           din,
  output logic [W-1:0]           dout,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr, r_rd;
  logic [AW:0] r_cnt;
  logic w_push, w_pop;
  assign full = r_cnt == (AW+1)'(DEPTH);
  assign empty = r_cnt == '0;
  assign w_pop = pop && !empty;
  assign w_push = push && (!full || w_pop);
  assign count = r_cnt;
  assign dout = r_mem[r_rd];
  always_ff @(posedge clk) begin
    if (w_push && !flush) r_mem[r_wr] <= din;
  end
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_wr <= '0;
      r_rd <= '0;
      r_cnt <= '0;
    end else begin
      r_wr <= w_push ? r_wr + 1'b1 : r_wr;
      r_rd <= w_pop ? r_rd + 1'b1 : r_rd;
      r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end
endmodule

// File: rtl/vliw_fetch.sv
// vliw_fetch: bundle PC generation, single-outstanding imem fetch FSM, bundle buffering and redirect squash
module vliw_fetch import vliw_pkg::*; #(
  parameter int          NUM_SLOTS = 4,
  parameter logic [31:0] RESET_PC  = 32'h0,
  parameter int          BUF_DEPTH = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        stall,
  input  logic                        branch_taken,
  input  logic [31:0]                 new_pc,
  output logic                        imem_req,
  output logic [31:0]                 imem_addr,
  input  logic                        imem_gnt,
  input  logic                        imem_rvalid,
  input  logic [NUM_SLOTS*INST_W-1:0] imem_rdata,
  output logic                        bundle_valid,
  output logic [NUM_SLOTS*INST_W-1:0] bundle,
  output logic [31:0]                 bundle_pc
);
  localparam int BW = NUM_SLOTS * INST_W;
  localparam int BB = 4 * NUM_SLOTS;
  localparam int CW = $clog2(BUF_DEPTH) + 1;
  fetch_state_t r_state;
  logic [31:0] r_pc, r_req_pc;
  logic [BW+31:0] w_head;
  logic [CW-1:0] w_count, w_free;
  logic w_full, w_empty, w_push, w_pop;
  // the in-flight request of WAIT already owns a buffer slot
  assign w_free = CW'(BUF_DEPTH) - w_count - CW'(r_state == WAIT);
  assign w_pop = !w_empty && !stall && !branch_taken;
  assign w_push = r_state == WAIT && imem_rvalid && !branch_taken && (!w_full || w_pop);
  fetch_buffer #(.W(BW + 32), .DEPTH(BUF_DEPTH)) u_buf (
    .clk(clk),
    .rst(rst),
    .push(w_push),
    .pop(w_pop),
    .flush(branch_taken),
    .din({imem_rdata, r_req_pc}),
    .dout(w_head),
    .count(w_count),
    .full(w_full),
    .empty(w_empty)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_pc <= RESET_PC;
      r_req_pc <= '0;
    end else if (branch_taken) begin
      r_pc <= new_pc & ~(32'(BB) - 32'd1);
      // a granted request whose data is still to come must be swallowed
      r_state <= ((r_state == REQ && imem_gnt) ||
                  ((r_state == WAIT || r_state == DROP) && !imem_rvalid)) ? DROP : REQ;
    end else begin
      case (r_state)
        IDLE: if (w_free != '0) r_state <= REQ;
        REQ: if (imem_gnt) begin
          r_state <= WAIT;
          r_pc <= r_pc + 32'(BB);
          r_req_pc <= r_pc;
        end
        WAIT: if (imem_rvalid) r_state <= (w_free != '0 || w_pop) ? REQ : IDLE;
        DROP: if (imem_rvalid) r_state <= REQ;
        default: r_state <= IDLE;
      endcase
    end
  end
  assign imem_req = r_state == REQ;
  assign imem_addr = r_pc;
  assign bundle_valid = !w_empty;
  assign bundle = w_empty ? {NUM_SLOTS{NOP_INST}} : w_head[BW+31:32];
  assign bundle_pc = w_empty ? 32'h0 : w_head[31:0];
endmodule

// File: tb/tb_vliw_fetch.sv
// tb_vliw_fetch: directed checks of fetch sequencing, stall fill, redirect squash, PC wrap and reset
module tb_vliw_fetch;
  import vliw_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1, stall = 1'b0, branch_taken = 1'b0;
  logic [31:0] new_pc = '0;
  logic imem_gnt = 1'b0, imem_rvalid = 1'b0;
  logic [127:0] imem_rdata = '0;
  logic imem_req, bundle_valid;
  logic [31:0] imem_addr, bundle_pc;
  logic [127:0] bundle;
  logic req5, bv5;
  logic [31:0] addr5, bpc5;
  logic [127:0] b5;
  logic [31:0] pend = '0;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  vliw_fetch u_dut (
    .clk(clk), .rst(rst), .stall(stall), .branch_taken(branch_taken), .new_pc(new_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .bundle_valid(bundle_valid), .bundle(bundle), .bundle_pc(bundle_pc)
  );

  vliw_fetch #(.RESET_PC(32'hFFFF_FFE0)) u_dut5 (
    .clk(clk), .rst(rst), .stall(stall), .branch_taken(branch_taken), .new_pc(new_pc),
    .imem_req(req5), .imem_addr(addr5), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .bundle_valid(bv5), .bundle(b5), .bundle_pc(bpc5)
  );

  function automatic logic [127:0] mk(input logic [31:0] a);
    logic [127:0] r;
    for (int i = 0; i < 4; i++) r[i*32 +: 32] = 32'hC000_0000 | (a + 32'(4 * i));
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chkb(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic g, input logic rv);
    imem_gnt = g;
    imem_rvalid = rv;
    imem_rdata = rv ? mk(pend) : '0;
    if (g) pend = imem_addr;
    @(negedge clk);
  endtask

  // rvalid is only legal while a granted request is outstanding
  always @(negedge clk) begin
    #2;
    if (!rst) assert (!(imem_rvalid && (u_dut.r_state == IDLE || u_dut.r_state == REQ))) else begin
      errors++;
      $error("FAIL protocol rvalid in IDLE/REQ");
    end
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_valid", 32'(bundle_valid), 32'd0);
    chkb("rst_bundle", bundle, 128'd0);
    chk("rst_pc", bundle_pc, 32'h0);
    chk("rst_req5", 32'(req5), 32'd0);
    // 1 + 5: sequential stream, wrap on the second instance
    rst = 1'b0;
    cyc(0, 0);
    chk("t1_req", 32'(imem_req), 32'd1);
    chk("t1_addr0", imem_addr, 32'h0);
    chk("t5_addr0", addr5, 32'hFFFF_FFE0);
    cyc(1, 0);
    chk("t1_wait_req", 32'(imem_req), 32'd0);
    chk("t1_wait_valid", 32'(bundle_valid), 32'd0);
    cyc(0, 1);
    chk("t1_valid0", 32'(bundle_valid), 32'd1);
    chk("t1_pc0", bundle_pc, 32'h0);
    chkb("t1_bundle0", bundle, mk(32'h0));
    chk("t1_addr1", imem_addr, 32'h10);
    chk("t5_addr1", addr5, 32'hFFFF_FFF0);
    cyc(1, 0);
    chk("t1_popped", 32'(bundle_valid), 32'd0);
    cyc(0, 1);
    chk("t1_pc1", bundle_pc, 32'h10);
    chk("t1_addr2", imem_addr, 32'h20);
    chk("t5_addr2", addr5, 32'h0);
    cyc(1, 0);
    cyc(0, 1);
    chk("t1_pc2", bundle_pc, 32'h20);
    chk("t1_addr3", imem_addr, 32'h30);
    // 2: stall fills buffer to two, request stops
    stall = 1'b1;
    cyc(1, 0);
    chk("t2_hold0", bundle_pc, 32'h20);
    cyc(0, 1);
    chk("t2_req_off", 32'(imem_req), 32'd0);
    repeat (4) cyc(0, 0);
    chk("t2_req_still_off", 32'(imem_req), 32'd0);
    chk("t2_hold_valid", 32'(bundle_valid), 32'd1);
    chk("t2_hold_pc", bundle_pc, 32'h20);
    stall = 1'b0;
    cyc(0, 0);
    chk("t2_pop1", bundle_pc, 32'h30);
    chkb("t2_pop1_bundle", bundle, mk(32'h30));
    cyc(0, 0);
    chk("t2_empty", 32'(bundle_valid), 32'd0);
    chk("t2_rereq", 32'(imem_req), 32'd1);
    chk("t2_addr", imem_addr, 32'h40);
    // 3: redirect while WAIT with a valid bundle under stall
    stall = 1'b1;
    cyc(1, 0);
    cyc(0, 1);
    cyc(1, 0);
    chk("t3_pre_pc", bundle_pc, 32'h40);
    branch_taken = 1'b1;
    new_pc = 32'h104;
    cyc(0, 0);
    branch_taken = 1'b0;
    chk("t3_squash", 32'(bundle_valid), 32'd0);
    chkb("t3_nop", bundle, 128'd0);
    chk("t3_pc0", bundle_pc, 32'h0);
    chk("t3_drop", 32'(u_dut.r_state), 32'(DROP));
    chk("t3_req_off", 32'(imem_req), 32'd0);
    stall = 1'b0;
    cyc(0, 1);
    chk("t3_stale", 32'(bundle_valid), 32'd0);
    chk("t3_req", 32'(imem_req), 32'd1);
    chk("t3_addr", imem_addr, 32'h100);
    cyc(1, 0);
    cyc(0, 1);
    chk("t3_target", bundle_pc, 32'h100);
    chkb("t3_target_bundle", bundle, mk(32'h100));
    // 4: redirect with full buffer and stall held
    stall = 1'b1;
    cyc(1, 0);
    cyc(0, 1);
    chk("t4_full_pc", bundle_pc, 32'h100);
    chk("t4_full_req", 32'(imem_req), 32'd0);
    branch_taken = 1'b1;
    new_pc = 32'h20C;
    cyc(0, 0);
    branch_taken = 1'b0;
    chk("t4_flush", 32'(bundle_valid), 32'd0);
    chk("t4_req", 32'(imem_req), 32'd1);
    chk("t4_addr", imem_addr, 32'h200);
    cyc(1, 0);
    cyc(0, 1);
    chk("t4_valid", 32'(bundle_valid), 32'd1);
    chk("t4_target", bundle_pc, 32'h200);
    // redirect in REQ without and then with grant
    branch_taken = 1'b1;
    new_pc = 32'h300;
    cyc(0, 0);
    chk("rq_addr", imem_addr, 32'h300);
    chk("rq_req", 32'(imem_req), 32'd1);
    chk("rq_flush", 32'(bundle_valid), 32'd0);
    new_pc = 32'h400;
    cyc(1, 0);
    branch_taken = 1'b0;
    chk("rg_drop", 32'(u_dut.r_state), 32'(DROP));
    chk("rg_req_off", 32'(imem_req), 32'd0);
    cyc(0, 1);
    chk("rg_addr", imem_addr, 32'h400);
    chk("rg_no_push", 32'(bundle_valid), 32'd0);
    // 6: reset while waiting, rvalid lands during reset
    stall = 1'b0;
    cyc(1, 0);
    rst = 1'b1;
    cyc(0, 1);
    rst = 1'b0;
    chk("t6_valid", 32'(bundle_valid), 32'd0);
    chk("t6_req", 32'(imem_req), 32'd0);
    chk("t6_idle", 32'(u_dut.r_state), 32'(IDLE));
    cyc(0, 0);
    chk("t6_addr", imem_addr, 32'h0);
    chk("t6_addr5", addr5, 32'hFFFF_FFE0);
    cyc(1, 0);
    cyc(0, 1);
    chk("t6_first_valid", 32'(bundle_valid), 32'd1);
    chk("t6_first_pc", bundle_pc, 32'h0);
    cyc(0, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
